bus_write_arbiter: RTL and testbench

BUS_WRITE_ARBITER -- requirements
Module: bus_write_arbiter

---
 rtl/bus_write_arbiter_if.sv | 34 +++
 rtl/bus_write_arbiter.sv | 127 ++++++++++++
 tb/tb_bus_write_arbiter.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/bus_write_arbiter_if.sv
// Bundle of request, grant and register-load signals between the write
// requesters and the bus write arbiter.
//
// Handshake: req[i] is a level request. The requester holds it, with
// dest/data stable, until it sees gnt[i] high for exactly one cycle. It drops
// req[i] on the clock edge that ends that gnt cycle. If req[i] is still high
// once the arbiter is back in IDLE, that is a new request. dest/data are
// captured when the request wins, so the requester may change them after the
// grant.
interface bus_write_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int NREG  = 16,
   parameter int WIDTH = 32
);
   logic [NREQ-1:0]       req;
   logic [NREQ*4-1:0]     dest;
   logic [NREQ*WIDTH-1:0] data;
   logic [NREQ-1:0]       gnt;
   logic [WIDTH-1:0]      bus_out;
   logic [NREG-1:0]       rin;
   logic                  busy;
   logic [7:0]            wr_count;
   logic                  dbg_state;   // 0 = IDLE, 1 = WRITE

   modport master (
      output req, dest, data,
      input  gnt, bus_out, rin, busy, wr_count, dbg_state
   );

   modport slave (
      input  req, dest, data,
      output gnt, bus_out, rin, busy, wr_count, dbg_state
   );
endinterface

// File: rtl/bus_write_arbiter.sv
// Round-robin arbiter that lets one of NREQ requesters drive a shared write
// bus for one cycle and pulses the load enable of the addressed register.
// A write takes two cycles: an IDLE cycle that samples the requests and a
// WRITE cycle that drives the bus.
module bus_write_arbiter #(
   parameter int NREQ  = 4,
   parameter int NREG  = 16,
   parameter int WIDTH = 32
) (
   input  logic                 clk,
   input  logic                 clr,
   bus_write_arbiter_if.slave   bus
);

   localparam int PW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic {
      S_IDLE  = 1'b0,
      S_WRITE = 1'b1
   } state_t;

   state_t           state_q;
   logic [PW-1:0]    ptr_q;
   logic [PW-1:0]    win_q;
   logic [NREQ-1:0]  gnt_q;
   logic [NREG-1:0]  rin_q;
   logic [WIDTH-1:0] bus_q;
   logic             busy_q;
   logic [7:0]       cnt_q;

   logic             any_req;
   logic [PW-1:0]    win_d;
   logic [NREQ-1:0]  gnt_d;
   logic [NREG-1:0]  rin_d;
   logic [3:0]       dest_d;
   logic [WIDTH-1:0] data_d;
   logic [PW-1:0]    ptr_d;
   logic [7:0]       cnt_d;

   // Round-robin search starting at ptr_q, wrapping past NREQ-1 back to 0.
   always_comb begin
      logic [PW-1:0] cand;
      int            idx;
      any_req = 1'b0;
      win_d   = '0;
      cand    = '0;
      idx     = 0;
      for (int k = 0; k < NREQ; k++) begin
         idx = int'(ptr_q) + k;
         if (idx >= NREQ) idx = idx - NREQ;
         cand = PW'(idx);
         if (!any_req && bus.req[cand]) begin
            any_req = 1'b1;
            win_d   = cand;
         end
      end
   end

   // Winner's dest/data mux and one-hot decodes; dest >= NREG decodes to no rin.
   always_comb begin
      dest_d = '0;
      data_d = '0;
      gnt_d  = '0;
      rin_d  = '0;
      for (int i = 0; i < NREQ; i++) begin
         if (int'(win_d) == i) begin
            dest_d   = bus.dest[i*4 +: 4];
            data_d   = bus.data[i*WIDTH +: WIDTH];
            gnt_d[i] = any_req;
         end
      end
      for (int r = 0; r < NREG; r++) begin
         rin_d[r] = (int'(dest_d) == r);
      end
   end

   // Pointer advance past the last winner and saturating write counter.
   always_comb begin
      ptr_d = (int'(win_q) == NREQ - 1) ? '0 : win_q + PW'(1);
      cnt_d = (cnt_q == 8'hFF) ? cnt_q : cnt_q + 8'd1;
   end

   // Arbiter FSM; bus_q and rin_q double as the captured data/destination,
   // so later changes on the requester side cannot reach the bus.
   always_ff @(posedge clk) begin
      if (clr) begin
         state_q <= S_IDLE;
         ptr_q   <= '0;
         win_q   <= '0;
         gnt_q   <= '0;
         rin_q   <= '0;
         bus_q   <= '0;
         busy_q  <= 1'b0;
         cnt_q   <= '0;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (any_req) begin
                  win_q   <= win_d;
                  gnt_q   <= gnt_d;
                  rin_q   <= rin_d;
                  bus_q   <= data_d;
                  busy_q  <= 1'b1;
                  state_q <= S_WRITE;
               end
            end
            S_WRITE: begin
               gnt_q   <= '0;
               rin_q   <= '0;
               busy_q  <= 1'b0;
               ptr_q   <= ptr_d;
               cnt_q   <= cnt_d;
               state_q <= S_IDLE;
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign bus.gnt       = gnt_q;
   assign bus.rin       = rin_q;
   assign bus.bus_out   = bus_q;
   assign bus.busy      = busy_q;
   assign bus.wr_count  = cnt_q;
   assign bus.dbg_state = state_q;

endmodule

// File: tb/tb_bus_write_arbiter.sv
// Directed bench for bus_write_arbiter: a default instance (NREG=16) and a
// second instance with NREG=8 for the out-of-range destination case.
module tb_bus_write_arbiter;

   logic clk;
   logic clr;
   int   total;
   int   bad;
   logic [3:0] exp_q[$];

   bus_write_arbiter_if #(.NREQ(4), .NREG(16), .WIDTH(32)) bus_a ();
   bus_write_arbiter_if #(.NREQ(4), .NREG(8),  .WIDTH(32)) bus_b ();

   bus_write_arbiter #(.NREQ(4), .NREG(16), .WIDTH(32)) dut_a (
      .clk (clk),
      .clr (clr),
      .bus (bus_a.slave)
   );

   bus_write_arbiter #(.NREQ(4), .NREG(8), .WIDTH(32)) dut_b (
      .clk (clk),
      .clr (clr),
      .bus (bus_b.slave)
   );

   // clock
   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic do_reset();
      clr = 1'b1;
      tick();
      tick();
      clr = 1'b0;
   endtask

   initial begin
      logic [3:0] e;
      total = 0;
      bad   = 0;
      clr   = 1'b0;
      bus_a.req = '0; bus_a.dest = '0; bus_a.data = '0;
      bus_b.req = '0; bus_b.dest = '0; bus_b.data = '0;
      #1;

      // reset state
      do_reset();
      chk("rst_gnt",  bus_a.gnt,      4'h0);
      chk("rst_rin",  bus_a.rin,      16'h0);
      chk("rst_busy", bus_a.busy,     1'b0);
      chk("rst_bus",  bus_a.bus_out,  32'h0);
      chk("rst_cnt",  bus_a.wr_count, 8'd0);

      // single write: requester 0 to register 5
      bus_a.req = 4'b0001;
      bus_a.dest[3:0] = 4'd5;
      bus_a.data[31:0] = 32'hFFFF_FFFE;
      tick();
      chk("w1_gnt",  bus_a.gnt,     4'b0001);
      chk("w1_rin",  bus_a.rin,     16'h0020);
      chk("w1_bus",  bus_a.bus_out, 32'hFFFF_FFFE);
      chk("w1_busy", bus_a.busy,    1'b1);
      bus_a.req = 4'b0000;
      bus_a.data[31:0] = 32'h1234_5678;   // must not reach the bus
      tick();
      chk("w1_gnt0", bus_a.gnt,      4'b0000);
      chk("w1_rin0", bus_a.rin,      16'h0);
      chk("w1_busy0", bus_a.busy,    1'b0);
      chk("w1_cnt",  bus_a.wr_count, 8'd1);
      chk("w1_hold", bus_a.bus_out,  32'hFFFF_FFFE);

      // all four requesting: order 0,1,2,3,0,1,2,3
      do_reset();
      for (int i = 0; i < 4; i++) begin
         bus_a.dest[i*4 +: 4]   = 4'(i + 8);
         bus_a.data[i*32 +: 32] = 32'hA0 + 32'(i);
      end
      for (int n = 0; n < 8; n++) exp_q.push_back(4'(1 << (n % 4)));
      bus_a.req = 4'b1111;
      for (int n = 0; n < 8; n++) begin
         tick();
         e = exp_q.pop_front();
         chk("rr_gnt",  bus_a.gnt,  e);
         chk("rr_busy", bus_a.busy, 1'b1);
         chk("rr_bus",  bus_a.bus_out, 32'hA0 + 32'(n % 4));
         chk("rr_rin",  bus_a.rin,  16'(1 << ((n % 4) + 8)));
         tick();
         if (n == 7) bus_a.req = 4'b0000;
         chk("rr_gap", bus_a.gnt, 4'b0000);
      end
      chk("rr_cnt", bus_a.wr_count, 8'd8);

      // pointer wrap after grant to 3: req=1001 -> 0 then 3
      bus_a.req = 4'b1001;
      tick();
      chk("wrap_g0", bus_a.gnt, 4'b0001);
      bus_a.req = 4'b1000;
      tick();
      tick();
      chk("wrap_g3", bus_a.gnt, 4'b1000);
      bus_a.req = 4'b0000;
      tick();
      chk("wrap_cnt", bus_a.wr_count, 8'd10);

      // request withdrawn before sampling: no grant
      bus_a.req = 4'b0010;
      #2;
      bus_a.req = 4'b0000;
      tick();
      chk("wd_gnt",  bus_a.gnt,  4'b0000);
      chk("wd_busy", bus_a.busy, 1'b0);

      // out-of-range destination on the NREG=8 instance
      bus_b.req = 4'b0010;
      bus_b.dest[7:4] = 4'hF;
      bus_b.data[63:32] = 32'hCAFE_0001;
      tick();
      chk("oor_gnt", bus_b.gnt, 4'b0010);
      chk("oor_rin", bus_b.rin, 8'h00);
      bus_b.req = 4'b0000;
      tick();
      chk("oor_cnt", bus_b.wr_count, 8'd1);
      bus_b.req = 4'b0010;
      bus_b.dest[7:4] = 4'h7;
      tick();
      chk("top_rin", bus_b.rin, 8'h80);
      bus_b.req = 4'b0000;
      tick();

      // clr during the WRITE cycle of a grant to requester 2
      bus_a.req = 4'b0100;
      bus_a.dest[11:8] = 4'd3;
      bus_a.data[95:64] = 32'h5555_AAAA;
      tick();
      chk("clw_gnt", bus_a.gnt, 4'b0100);
      clr = 1'b1;
      bus_a.req = 4'b0000;
      tick();
      clr = 1'b0;
      chk("clw_gnt0", bus_a.gnt,      4'b0000);
      chk("clw_rin0", bus_a.rin,      16'h0);
      chk("clw_busy", bus_a.busy,     1'b0);
      chk("clw_bus",  bus_a.bus_out,  32'h0);
      chk("clw_cnt",  bus_a.wr_count, 8'd0);
      tick();
      // ptr back at 0: 1100 picks 2 (a counted write would have moved it to 3)
      bus_a.req = 4'b1100;
      tick();
      chk("clw_regnt", bus_a.gnt, 4'b0100);
      chk("clw_rerin", bus_a.rin, 16'h0008);
      bus_a.req = 4'b0000;
      tick();
      chk("clw_recnt", bus_a.wr_count, 8'd1);

      // saturation: 260 writes from requester 0
      do_reset();
      bus_a.req = 4'b0001;
      for (int n = 0; n < 260; n++) begin
         tick();
         tick();
      end
      bus_a.req = 4'b0000;
      chk("sat_cnt", bus_a.wr_count, 8'd255);
      tick();
      chk("sat_idle", bus_a.busy, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
